// File: rtl/gat_pkg.sv
// Shared types and widths for the H-matrix CSR loader.
// Holds the matrix geometry, the loader FSM state encoding, the per-row
// info record {nnz, nonempty}, and the nnz saturation helper.
package gat_pkg;

  localparam int unsigned DATA_WIDTH     = 8;
  localparam int unsigned H_NUM_OF_ROWS  = 5;
  localparam int unsigned H_NUM_OF_COLS  = 5;
  localparam int unsigned COL_IDX_WIDTH  = $clog2(H_NUM_OF_COLS);
  localparam int unsigned ROW_LEN_WIDTH  = $clog2(H_NUM_OF_COLS + 1);
  localparam int unsigned ROW_INFO_WIDTH = ROW_LEN_WIDTH + 1;
  localparam int unsigned ROW_CNT_WIDTH  = $clog2(H_NUM_OF_ROWS);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    FULL = 2'd2
  } loader_state_e;

  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0] nnz;
    logic                     nonempty;
  } row_info_t;

  // Clamp a header nonzero count to the row capacity.
  function automatic logic [ROW_LEN_WIDTH-1:0] sat_nnz(input logic [ROW_LEN_WIDTH-1:0] n);
    return (n > ROW_LEN_WIDTH'(H_NUM_OF_COLS)) ? ROW_LEN_WIDTH'(H_NUM_OF_COLS) : n;
  endfunction

endpackage

// File: rtl/h_csr_loader.sv
// h_csr_loader: assembles a CSR-ordered beat stream of the sparse feature
// matrix H into per-row register arrays and hands the full frame to the
// sparse-dense multiply stage with a valid/ready frame handshake.
//
// Ports:
//   clk, rst_n      clock (rising edge); asynchronous reset, active HIGH
//   in_valid/ready  beat handshake; in_ready is low while a frame is held
//   in_hdr          1 = header beat, in_value low bits carry the row nnz
//   in_col_idx      column of a data beat
//   in_value        data value (or header nnz)
//   row_col_idx_o   [row][entry] column indices, unwritten entries read 0
//   row_value_o     [row][entry] values, unwritten entries read 0
//   row_info_o      [row] {nnz, nonempty}
//   frame_valid_o   complete frame held stable
//   frame_ready_i   multiply stage takes the frame
//   err_o           sticky protocol error, cleared only by reset
//
// Optional build macro CSR_LOADER_CHECK_EN adds column-order/range and
// header-overflow checks that flag err_o (beats are still stored).
module h_csr_loader
  import gat_pkg::*;
(
  input  logic                                                       clk,
  input  logic                                                       rst_n,
  input  logic                                                       in_valid,
  output logic                                                       in_ready,
  input  logic                                                       in_hdr,
  input  logic [COL_IDX_WIDTH-1:0]                                   in_col_idx,
  input  logic [DATA_WIDTH-1:0]                                      in_value,
  output logic [H_NUM_OF_ROWS-1:0][H_NUM_OF_COLS-1:0][COL_IDX_WIDTH-1:0] row_col_idx_o,
  output logic [H_NUM_OF_ROWS-1:0][H_NUM_OF_COLS-1:0][DATA_WIDTH-1:0]    row_value_o,
  output row_info_t [H_NUM_OF_ROWS-1:0]                              row_info_o,
  output logic                                                       frame_valid_o,
  input  logic                                                       frame_ready_i,
  output logic                                                       err_o
);

  loader_state_e              r_state;
  logic [ROW_CNT_WIDTH-1:0]   r_row_cnt;
  logic [ROW_LEN_WIDTH-1:0]   r_ent_cnt;
  logic [ROW_LEN_WIDTH-1:0]   r_nnz;

  logic                       w_accept;
  logic                       w_last_row;
  logic                       w_last_ent;
  logic [ROW_LEN_WIDTH-1:0]   w_hdr_nnz;
  logic                       w_hdr_err;
  logic                       w_col_err;

  assign w_accept   = in_valid && in_ready;
  assign w_last_row = (r_row_cnt == ROW_CNT_WIDTH'(H_NUM_OF_ROWS - 1));
  assign w_last_ent = (r_ent_cnt == (r_nnz - ROW_LEN_WIDTH'(1)));
  assign w_hdr_nnz  = sat_nnz(in_value[ROW_LEN_WIDTH-1:0]);

`ifdef CSR_LOADER_CHECK_EN
  logic [COL_IDX_WIDTH-1:0] r_prev_col;

  // Columns within a row must be in range and strictly ascending.
  assign w_col_err = (in_col_idx >= COL_IDX_WIDTH'(H_NUM_OF_COLS)) ||
                     ((r_ent_cnt != '0) && (in_col_idx <= r_prev_col));
  assign w_hdr_err = (in_value[ROW_LEN_WIDTH-1:0] > ROW_LEN_WIDTH'(H_NUM_OF_COLS));

  // Last stored column of the current row, for the ordering check.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_prev_col <= '0;
    end else if (w_accept && (r_state == DATA) && !in_hdr) begin
      r_prev_col <= in_col_idx;
    end
  end
`else
  assign w_col_err = 1'b0;
  assign w_hdr_err = 1'b0;
`endif

  // Loader FSM, counters and frame register arrays.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state       <= HDR;
      r_row_cnt     <= '0;
      r_ent_cnt     <= '0;
      r_nnz         <= '0;
      in_ready      <= 1'b1;
      frame_valid_o <= 1'b0;
      err_o         <= 1'b0;
      row_col_idx_o <= '0;
      row_value_o   <= '0;
      row_info_o    <= '0;
    end else begin
      unique case (r_state)
        HDR: begin
          if (w_accept) begin
            if (in_hdr) begin
              row_info_o[r_row_cnt] <= '{nnz: w_hdr_nnz, nonempty: (w_hdr_nnz != '0)};
              r_ent_cnt             <= '0;
              r_nnz                 <= w_hdr_nnz;
              if (w_hdr_err) err_o <= 1'b1;
              // Empty row completes immediately without data beats.
              if (w_hdr_nnz == '0) begin
                if (w_last_row) begin
                  r_state       <= FULL;
                  in_ready      <= 1'b0;
                  frame_valid_o <= 1'b1;
                end else begin
                  r_row_cnt <= r_row_cnt + ROW_CNT_WIDTH'(1);
                end
              end else begin
                r_state <= DATA;
              end
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            if (!in_hdr) begin
              row_col_idx_o[r_row_cnt][r_ent_cnt] <= in_col_idx;
              row_value_o[r_row_cnt][r_ent_cnt]   <= in_value;
              r_ent_cnt                           <= r_ent_cnt + ROW_LEN_WIDTH'(1);
              if (w_col_err) err_o <= 1'b1;
              if (w_last_ent) begin
                if (w_last_row) begin
                  r_state       <= FULL;
                  in_ready      <= 1'b0;
                  frame_valid_o <= 1'b1;
                end else begin
                  r_state   <= HDR;
                  r_row_cnt <= r_row_cnt + ROW_CNT_WIDTH'(1);
                end
              end
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        FULL: begin
          // Handoff: clear the arrays so unwritten entries of the next frame read 0.
          if (frame_ready_i && frame_valid_o) begin
            r_state       <= HDR;
            r_row_cnt     <= '0;
            r_ent_cnt     <= '0;
            in_ready      <= 1'b1;
            frame_valid_o <= 1'b0;
            row_col_idx_o <= '0;
            row_value_o   <= '0;
            row_info_o    <= '0;
          end
        end
        default: begin
          r_state <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_h_csr_loader.sv
// Directed self-checking bench for h_csr_loader: full frames, back-pressure
// and handoff, input gaps, beat-type errors, mid-frame reset and the
// optional CSR_LOADER_CHECK_EN checks.
module tb_h_csr_loader;
  import gat_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic in_hdr;
  logic [COL_IDX_WIDTH-1:0] in_col_idx;
  logic [DATA_WIDTH-1:0]    in_value;
  logic [H_NUM_OF_ROWS-1:0][H_NUM_OF_COLS-1:0][COL_IDX_WIDTH-1:0] row_col_idx_o;
  logic [H_NUM_OF_ROWS-1:0][H_NUM_OF_COLS-1:0][DATA_WIDTH-1:0]    row_value_o;
  row_info_t [H_NUM_OF_ROWS-1:0] row_info_o;
  logic frame_valid_o;
  logic frame_ready_i;
  logic err_o;

  logic [H_NUM_OF_ROWS-1:0][H_NUM_OF_COLS-1:0][COL_IDX_WIDTH-1:0] exp_col;
  logic [H_NUM_OF_ROWS-1:0][H_NUM_OF_COLS-1:0][DATA_WIDTH-1:0]    exp_val;
  row_info_t [H_NUM_OF_ROWS-1:0] exp_info;

  int tests = 0;
  int fails = 0;
  bit gaps  = 1'b0;
`ifdef CSR_LOADER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  h_csr_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_hdr        (in_hdr),
    .in_col_idx    (in_col_idx),
    .in_value      (in_value),
    .row_col_idx_o (row_col_idx_o),
    .row_value_o   (row_value_o),
    .row_info_o    (row_info_o),
    .frame_valid_o (frame_valid_o),
    .frame_ready_i (frame_ready_i),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send(input logic hdr, input logic [COL_IDX_WIDTH-1:0] col, input logic [DATA_WIDTH-1:0] val);
    int n;
    n = 0;
    if (gaps && ($urandom_range(0, 1) == 1)) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid   = 1'b1;
    in_hdr     = hdr;
    in_col_idx = col;
    in_value   = val;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_ready", 256'(in_ready), 256'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic release_frame();
    frame_ready_i = 1'b1;
    @(posedge clk); #1;
    frame_ready_i = 1'b0;
  endtask

  task automatic check_arrays(input string tag);
    chk({tag, "_col"},  256'(row_col_idx_o), 256'(exp_col));
    chk({tag, "_val"},  256'(row_value_o),   256'(exp_val));
    chk({tag, "_info"}, 256'(row_info_o),    256'(exp_info));
  endtask

  // Frame 1: nnz = {2,0,1,3,1}; all beats but the last.
  task automatic frame1_head();
    send(1, 0, 8'd2); send(0, 0, 8'h11); send(0, 2, 8'h12);
    send(1, 0, 8'd0);
    send(1, 0, 8'd1); send(0, 4, 8'h31);
    send(1, 0, 8'd3); send(0, 1, 8'h41); send(0, 2, 8'h42); send(0, 4, 8'h43);
    send(1, 0, 8'd1);
  endtask

  task automatic frame1_tail();
    send(0, 3, 8'h51);
  endtask

  task automatic exp_frame1();
    exp_col = '0; exp_val = '0; exp_info = '0;
    exp_col[0][0] = 3'd0; exp_val[0][0] = 8'h11;
    exp_col[0][1] = 3'd2; exp_val[0][1] = 8'h12;
    exp_col[2][0] = 3'd4; exp_val[2][0] = 8'h31;
    exp_col[3][0] = 3'd1; exp_val[3][0] = 8'h41;
    exp_col[3][1] = 3'd2; exp_val[3][1] = 8'h42;
    exp_col[3][2] = 3'd4; exp_val[3][2] = 8'h43;
    exp_col[4][0] = 3'd3; exp_val[4][0] = 8'h51;
    exp_info[0] = '{nnz: 3'd2, nonempty: 1'b1};
    exp_info[1] = '{nnz: 3'd0, nonempty: 1'b0};
    exp_info[2] = '{nnz: 3'd1, nonempty: 1'b1};
    exp_info[3] = '{nnz: 3'd3, nonempty: 1'b1};
    exp_info[4] = '{nnz: 3'd1, nonempty: 1'b1};
  endtask

  // Frame 2: each row has one entry at column r with value 0x80+r.
  task automatic frame2();
    exp_col = '0; exp_val = '0; exp_info = '0;
    for (int r = 0; r < int'(H_NUM_OF_ROWS); r++) begin
      send(1, 0, 8'd1);
      send(0, 3'(r), 8'(8'h80 + r));
      exp_col[r][0] = 3'(r);
      exp_val[r][0] = 8'(8'h80 + r);
      exp_info[r]   = '{nnz: 3'd1, nonempty: 1'b1};
    end
  endtask

  logic [H_NUM_OF_COLS-1:0][DATA_WIDTH-1:0] exp_row3;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; in_hdr = 1'b0; in_col_idx = '0; in_value = '0;
    frame_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_frame_valid", 256'(frame_valid_o), 256'(0));
    chk("rst_err", 256'(err_o), 256'(0));
    exp_col = '0; exp_val = '0; exp_info = '0;
    check_arrays("rst");

    // Case 1: frame 1 back-to-back
    frame1_head();
    chk("c1_valid_before_last", 256'(frame_valid_o), 256'(0));
    frame1_tail();
    chk("c1_frame_valid", 256'(frame_valid_o), 256'(1));
    chk("c1_in_ready", 256'(in_ready), 256'(0));
    exp_frame1();
    check_arrays("c1");
    chk("c1_info_row1", 256'(row_info_o[1]), 256'(0));
    exp_row3 = '0;
    exp_row3[0] = 8'h41; exp_row3[1] = 8'h42; exp_row3[2] = 8'h43;
    chk("c1_value_row3", 256'(row_value_o[3]), 256'(exp_row3));
    chk("c1_err", 256'(err_o), 256'(0));

    // Case 2: back-pressure then handoff, then a second frame
    repeat (10) @(posedge clk);
    #1;
    check_arrays("c2_hold");
    chk("c2_hold_in_ready", 256'(in_ready), 256'(0));
    chk("c2_hold_valid", 256'(frame_valid_o), 256'(1));
    release_frame();
    chk("c2_rel_valid", 256'(frame_valid_o), 256'(0));
    chk("c2_rel_in_ready", 256'(in_ready), 256'(1));
    exp_col = '0; exp_val = '0; exp_info = '0;
    check_arrays("c2_cleared");
    frame2();
    chk("c2_f2_valid", 256'(frame_valid_o), 256'(1));
    check_arrays("c2_f2");
    release_frame();

    // Case 3: frame 1 with random input gaps
    gaps = 1'b1;
    frame1_head();
    frame1_tail();
    gaps = 1'b0;
    chk("c3_frame_valid", 256'(frame_valid_o), 256'(1));
    exp_frame1();
    check_arrays("c3");
    release_frame();

    // Case 4: data beat while expecting a header
    send(0, 1, 8'h99);
    chk("c4_err", 256'(err_o), 256'(1));
    chk("c4_not_valid", 256'(frame_valid_o), 256'(0));
    frame1_head();
    frame1_tail();
    chk("c4_frame_valid", 256'(frame_valid_o), 256'(1));
    exp_frame1();
    check_arrays("c4");
    chk("c4_err_sticky", 256'(err_o), 256'(1));
    release_frame();

    // Case 5: reset after two rows
    send(1, 0, 8'd2); send(0, 0, 8'h11); send(0, 2, 8'h12); send(1, 0, 8'd0);
    chk("c5_partial_valid", 256'(frame_valid_o), 256'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_col = '0; exp_val = '0; exp_info = '0;
    check_arrays("c5_rst");
    chk("c5_err", 256'(err_o), 256'(0));
    chk("c5_in_ready", 256'(in_ready), 256'(1));
    chk("c5_valid", 256'(frame_valid_o), 256'(0));
    frame2();
    chk("c5_f2_valid", 256'(frame_valid_o), 256'(1));
    check_arrays("c5_f2");
    release_frame();

    // Case 6: descending columns and oversized header
    send(1, 0, 8'd2); send(0, 3, 8'hA1); send(0, 1, 8'hA2);
    chk("c6_col_order_err", 256'(err_o), 256'(CHK));
    send(1, 0, 8'd0); send(1, 0, 8'd0); send(1, 0, 8'd0);
    send(1, 0, 8'd7);
    chk("c6_hdr_err", 256'(err_o), 256'(CHK));
    for (int c = 0; c < int'(H_NUM_OF_COLS); c++) send(0, 3'(c), 8'(8'hB0 + c));
    chk("c6_frame_valid", 256'(frame_valid_o), 256'(1));
    chk("c6_info_row4", 256'(row_info_o[4]), 256'(4'hB));
    chk("c6_col_row0", 256'(row_col_idx_o[0]), 256'(15'o00013));
    chk("c6_err_final", 256'(err_o), 256'(CHK));
    release_frame();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
